alu_seq: RTL
============

// Module: alu_seq
// PURPOSE
//   Parametrised multi-cycle successor to the combinational 8-bit ALU. Accepts one alu_op
//   per valid/ready handshake and returns a registered result plus Z80 status byte. Adds
//   ADC/SBC carry-in, iterative 1-bit/cycle shifts and rotates, and output backpressure.
//   Sits between the decode/register-file stage and the accumulator/flag writeback.
// PARAMETERS
//   WIDTH     8   operand/result width in bits (>=4)
//   HALF_BIT  4   H flag = carry/borrow out of bit HALF_BIT-1
//   CNT_W     $clog2(WIDTH+1)  localparam, shift counter width
// PORTS
//   clk          in   1      clock, all state on rising edge
//   reset        in   1      asynchronous, active-high reset
//   flush        in   1      synchronous abort: drop in-flight op and pending result
//   in_valid     in   1      operation request
//   in_ready     out  1      block can accept a request this cycle
//   opcode       in   alu_op ADD SUB AND OR XOR COMPARE SLL SRL SLA SRA ROL ROR INC DEC
//   a, b         in   WIDTH  operands; b = count for shifts/rotates
//   use_carry    in   1      ADD->ADC, SUB->SBC (ignored for other ops)
//   carry_in     in   1      current C flag
//   out_valid    out  1      result and status_flag valid
//   out_ready    in   1      consumer takes result
//   out          out  WIDTH  result
//   status_flag  out  8      7:S 6:Z 5:0 4:H 3:0 2:P/V 1:N 0:C
// BEHAVIOUR
//   Reset (async): state=IDLE, out_valid=0, out=0, status_flag=0; in_ready=0 while reset high.
//   FSM: IDLE -(accept, non-shift or count 0)-> DONE; IDLE -(accept, shift count n>0)-> SHIFT;
//     SHIFT: 1 bit per edge, counter n..1, -(counter==1)-> DONE; DONE -(out_ready)-> IDLE,
//     or DONE -> DONE/SHIFT if a new request is accepted on the same edge.
//   Accept = in_valid & in_ready; in_ready = (IDLE) | (DONE & out_ready); never in SHIFT.
//   Latency from accept edge E: out_valid high after E+1 (non-shift, n=0); after E+1+n (shift).
//   out/status_flag held stable while out_valid & !out_ready; change only on a new completion.
//   Operands/opcode/carry captured at accept; inputs ignored afterwards.
//   Arithmetic: WIDTH+1-bit internal sum; ADC=a+b+cin, SBC=a-b-cin (cin=carry_in&use_carry).
//     C = carry/borrow out of MSB; H = carry/borrow out of bit HALF_BIT-1;
//     P/V = signed overflow; N=1 for SUB, DEC, COMPARE, else 0.
//   INC/DEC: a+/-1; C preserved (= carry_in); H, P/V, N as arithmetic.
//   COMPARE: flags of a-b (no carry-in); out = a (accumulator unchanged).
//   AND/OR/XOR: C=0, N=0, H=1 for AND else 0, P/V = parity (1 = even ones).
//   Shifts: n = min(b, WIDTH) for SLL/SLA/SRL/SRA; n = b mod WIDTH for ROL/ROR.
//     SLL=SLA (zero fill); SRL zero fill; SRA MSB fill; rotates wrap.
//     C = last bit shifted/rotated out; n=0 -> out=a, C=carry_in. H=0, N=0, P/V = parity.
//   All ops: S = out[WIDTH-1], Z = (out==0); bits 5,3 always 0.
//   Unknown opcode: accepted, completes in 1 cycle, out=0, status_flag=0.
//   flush: state->IDLE, out_valid->0 next edge; a same-cycle request is NOT accepted.
//   reset mid-operation: immediate return to reset values; partial shift discarded.
// TESTING (WIDTH=8)
//   ADD a=0x7F b=0x01 -> out_valid 1 cycle later, out=0x80, status_flag=0x94.
//   SUB use_carry=1 carry_in=1 a=0x00 b=0x01 -> out=0xFE, status_flag=0x93.
//   SRA a=0x81 b=3 -> out_valid at E+4, in_ready=0 during SHIFT, out=0xF0, status_flag=0x84.
//   ROL a=0x81 b=9 (n=1) -> out_valid at E+2, out=0x03, status_flag=0x05.
//   out_ready=0 for 5 cycles after ADD result -> out/flags stable, in_ready=0; on out_ready=1
//     with in_valid=1 XOR a=0xFF b=0x0F, same-edge accept, next result out=0xF0, flags=0x84.
//   Assert reset at 3rd SHIFT cycle of SLL b=7 -> out_valid=0, status_flag=0 at once;
//     after release, INC a=0xFF carry_in=1 -> out=0x00, status_flag=0x51.

Source files
------------

// File: rtl/alu_seq_if.sv
`default_nettype none
// =============================================================================
// alu_seq_if : request/result handshake bundle between decode and alu_seq
// Rev 1.0
// =============================================================================
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       opcode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             use_carry;
  logic             carry_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic [7:0]       status_flag;

  modport master (
    output flush, in_valid, opcode, a, b, use_carry, carry_in, out_ready,
    input  in_ready, out_valid, out, status_flag
  );

  modport slave (
    input  flush, in_valid, opcode, a, b, use_carry, carry_in, out_ready,
    output in_ready, out_valid, out, status_flag
  );
endinterface
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// =============================================================================
// alu_seq : multi-cycle ALU, Z80 status byte, iterative shifts, backpressure
// Rev 1.0
// =============================================================================
module alu_seq #(
  parameter int WIDTH    = 8,
  parameter int HALF_BIT = 4
) (
  input logic      clk,
  input logic      reset,
  alu_seq_if.slave alu
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int MSB   = WIDTH - 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_AND = 4'd2,  OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4,  OP_CMP = 4'd5,  OP_SLL = 4'd6,  OP_SRL = 4'd7;
  localparam logic [3:0] OP_SLA = 4'd8,  OP_SRA = 4'd9,  OP_ROL = 4'd10, OP_ROR = 4'd11;
  localparam logic [3:0] OP_INC = 4'd12, OP_DEC = 4'd13;

  localparam logic [WIDTH-1:0] W_VAL   = WIDTH'(WIDTH);
  localparam logic [WIDTH-1:0] ONE_W   = WIDTH'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  function automatic logic [7:0] mk_flags(input logic [WIDTH-1:0] r, input logic h,
                                          input logic pv, input logic n, input logic c);
    return {r[MSB], ~|r, 1'b0, h, 1'b0, pv, n, c};
  endfunction

  function automatic logic [7:0] mk_logic(input logic [WIDTH-1:0] r, input logic h,
                                          input logic c);
    return mk_flags(r, h, ~^r, 1'b0, c);
  endfunction

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [7:0]       flag_q, flag_d;

  logic             accept, is_shift, go_shift;
  logic [CNT_W-1:0] n_w;
  logic [WIDTH-1:0] opb, imm_res, step_v;
  logic [WIDTH:0]   sum;
  logic             cin, sub, half_c, ovf, step_bo;
  logic [7:0]       imm_flag;

  assign accept   = alu.in_valid & alu.in_ready;
  assign is_shift = alu.opcode inside {OP_SLL, OP_SRL, OP_SLA, OP_SRA, OP_ROL, OP_ROR};
  // Rotates wrap the count; linear shifts saturate at a full-width shift.
  assign n_w      = (alu.opcode == OP_ROL || alu.opcode == OP_ROR) ? CNT_W'(alu.b % W_VAL)
                  : (alu.b >= W_VAL) ? CNT_W'(WIDTH) : CNT_W'(alu.b);
  assign go_shift = is_shift && (n_w != '0);

  always_comb begin : p_arith
    opb = alu.b;
    cin = 1'b0;
    sub = 1'b0;
    case (alu.opcode)
      OP_ADD:  cin = alu.use_carry & alu.carry_in;
      OP_SUB:  begin sub = 1'b1; cin = alu.use_carry & alu.carry_in; end
      OP_CMP:  sub = 1'b1;
      OP_INC:  opb = ONE_W;
      OP_DEC:  begin opb = ONE_W; sub = 1'b1; end
      default: ;
    endcase
    sum = sub ? ({1'b0, alu.a} - {1'b0, opb} - {{WIDTH{1'b0}}, cin})
              : ({1'b0, alu.a} + {1'b0, opb} + {{WIDTH{1'b0}}, cin});
    // Carry/borrow into bit HALF_BIT recovered from the operand and sum bits there.
    half_c = alu.a[HALF_BIT] ^ opb[HALF_BIT] ^ sum[HALF_BIT];
    ovf    = sub ? ((alu.a[MSB] != opb[MSB]) && (sum[MSB] != alu.a[MSB]))
                 : ((alu.a[MSB] == opb[MSB]) && (sum[MSB] != alu.a[MSB]));
  end

  always_comb begin : p_result
    imm_res  = '0;
    imm_flag = 8'h00;
    case (alu.opcode)
      OP_ADD, OP_SUB: begin
        imm_res  = sum[MSB:0];
        imm_flag = mk_flags(sum[MSB:0], half_c, ovf, sub, sum[WIDTH]);
      end
      OP_CMP: begin
        imm_res  = alu.a;
        imm_flag = mk_flags(sum[MSB:0], half_c, ovf, 1'b1, sum[WIDTH]);
      end
      OP_INC, OP_DEC: begin
        imm_res  = sum[MSB:0];
        imm_flag = mk_flags(sum[MSB:0], half_c, ovf, sub, alu.carry_in);
      end
      OP_AND: begin imm_res = alu.a & alu.b; imm_flag = mk_logic(alu.a & alu.b, 1'b1, 1'b0); end
      OP_OR:  begin imm_res = alu.a | alu.b; imm_flag = mk_logic(alu.a | alu.b, 1'b0, 1'b0); end
      OP_XOR: begin imm_res = alu.a ^ alu.b; imm_flag = mk_logic(alu.a ^ alu.b, 1'b0, 1'b0); end
      OP_SLL, OP_SRL, OP_SLA, OP_SRA, OP_ROL, OP_ROR: begin
        imm_res  = alu.a;
        imm_flag = mk_logic(alu.a, 1'b0, alu.carry_in);
      end
      default: ;
    endcase
  end

  always_comb begin : p_step
    step_v  = sh_q;
    step_bo = 1'b0;
    case (op_q)
      OP_SLL, OP_SLA: begin step_v = {sh_q[MSB-1:0], 1'b0};      step_bo = sh_q[MSB]; end
      OP_SRL:         begin step_v = {1'b0, sh_q[MSB:1]};         step_bo = sh_q[0];   end
      OP_SRA:         begin step_v = {sh_q[MSB], sh_q[MSB:1]};    step_bo = sh_q[0];   end
      OP_ROL:         begin step_v = {sh_q[MSB-1:0], sh_q[MSB]};  step_bo = sh_q[MSB]; end
      OP_ROR:         begin step_v = {sh_q[0], sh_q[MSB:1]};      step_bo = sh_q[0];   end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin : p_state
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin : p_next
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = go_shift ? S_SHIFT : S_DONE;
      S_SHIFT: if (cnt_q == CNT_ONE) state_d = S_DONE;
      S_DONE: begin
        if (accept)             state_d = go_shift ? S_SHIFT : S_DONE;
        else if (alu.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (alu.flush) state_d = S_IDLE;
  end

  always_comb begin : p_outputs
    alu.in_ready  = !reset && !alu.flush &&
                    ((state_q == S_IDLE) || ((state_q == S_DONE) && alu.out_ready));
    alu.out_valid = (state_q == S_DONE);
  end

  assign alu.out         = out_q;
  assign alu.status_flag = flag_q;

  always_comb begin : p_data
    out_d  = out_q;
    flag_d = flag_q;
    sh_d   = sh_q;
    cnt_d  = cnt_q;
    op_d   = op_q;
    if (accept) begin
      if (go_shift) begin
        sh_d  = alu.a;
        cnt_d = n_w;
        op_d  = alu.opcode;
      end else begin
        out_d  = imm_res;
        flag_d = imm_flag;
      end
    end else if (state_q == S_SHIFT && !alu.flush) begin
      sh_d  = step_v;
      cnt_d = cnt_q - CNT_ONE;
      if (cnt_q == CNT_ONE) begin
        out_d  = step_v;
        flag_d = mk_logic(step_v, 1'b0, step_bo);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin : p_regs
    if (reset) begin
      out_q  <= '0;
      flag_q <= 8'h00;
      sh_q   <= '0;
      cnt_q  <= '0;
      op_q   <= 4'd0;
    end else begin
      out_q  <= out_d;
      flag_q <= flag_d;
      sh_q   <= sh_d;
      cnt_q  <= cnt_d;
      op_q   <= op_d;
    end
  end
endmodule
`default_nettype wire
